pwm_multi_dt: RTL and testbench

- Parametrised multi-channel PWM generator for the BLDC bridge. Successor to the single-channel 8-bit PWM.
- One shared edge-aligned counter with a programmable period. Per-channel duty values pass through shadow registers, which update only at the period boundary.
- Each channel drives a complementary high-side/low-side pair with programmable dead time and a full-duty flag.
- Sits between the commutation/speed controller (duty, period, LOAD) and the gate-driver pins (HI/LO).

---
 rtl/pwm_multi_dt.sv | 158 +++++++++++++++
 tb/tb_pwm_multi_dt.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_dt.sv
// Multi-channel edge-aligned PWM with shadowed duty/period,
// complementary outputs, dead time and full-duty flags.
module pwm_multi_dt #(
    parameter int WIDTH = 8,
    parameter int CH    = 3,
    parameter int DT_W  = 4
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                E,
    input  logic [WIDTH-1:0]    PERIOD,
    input  logic [CH*WIDTH-1:0] DUTY,
    input  logic                LOAD,
    input  logic [DT_W-1:0]     DT,
    output logic [CH-1:0]       HI,
    output logic [CH-1:0]       LO,
    output logic [CH-1:0]       FULL,
    output logic                SYNC
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LO   = 3'd1;
    localparam logic [2:0] S_DTH  = 3'd2;
    localparam logic [2:0] S_HI   = 3'd3;
    localparam logic [2:0] S_DTL  = 3'd4;

    logic [WIDTH-1:0]    cnt;
    logic [WIDTH-1:0]    per_sh;
    logic [CH*WIDTH-1:0] duty_sh;
    logic                pending;
    logic                bnd;
    logic                upd;
    logic [CH-1:0]       full_nxt;

    assign bnd = (cnt == per_sh);
    assign upd = bnd & (pending | LOAD);

    // Full flag: duty beyond the period keeps the high side on
    always_comb begin
        full_nxt = '0;
        for (int i = 0; i < CH; i++) begin
            full_nxt[i] = E && (duty_sh[i*WIDTH +: WIDTH] > per_sh);
        end
    end

    // Shared counter, shadow registers, period sync and full flags
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt     <= '0;
            per_sh  <= '0;
            duty_sh <= '0;
            pending <= 1'b0;
            SYNC    <= 1'b0;
            FULL    <= '0;
        end else begin
            FULL <= full_nxt;
            if (!E) begin
                cnt     <= '0;
                per_sh  <= PERIOD;
                duty_sh <= DUTY;
                pending <= 1'b0;
                SYNC    <= 1'b0;
            end else begin
                cnt  <= bnd ? '0 : cnt + WIDTH'(1);
                SYNC <= bnd;
                if (upd) begin
                    per_sh  <= PERIOD;
                    duty_sh <= DUTY;
                    pending <= 1'b0;
                end else if (LOAD) begin
                    pending <= 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic            raw;
        logic [2:0]      st;
        logic [2:0]      nst;
        logic [DT_W-1:0] dtc;
        logic [DT_W-1:0] ndtc;
        logic            hi_q;
        logic            lo_q;

        assign raw   = (cnt < duty_sh[i*WIDTH +: WIDTH]);
        assign HI[i] = hi_q;
        assign LO[i] = lo_q;

        // Next-state logic: dead band on every side swap, abort on glitch
        always_comb begin
            nst  = st;
            ndtc = dtc;
            if (!E) begin
                nst = S_IDLE;
            end else begin
                unique case (st)
                    S_IDLE: nst = raw ? S_HI : S_LO;
                    S_LO: begin
                        if (raw) begin
                            if (DT == '0) begin
                                nst = S_HI;
                            end else begin
                                nst  = S_DTH;
                                ndtc = DT;
                            end
                        end
                    end
                    S_DTH: begin
                        if (!raw) begin
                            nst = S_LO;
                        end else if (dtc <= DT_W'(1)) begin
                            nst = S_HI;
                        end else begin
                            ndtc = dtc - DT_W'(1);
                        end
                    end
                    S_HI: begin
                        if (!raw) begin
                            if (DT == '0) begin
                                nst = S_LO;
                            end else begin
                                nst  = S_DTL;
                                ndtc = DT;
                            end
                        end
                    end
                    S_DTL: begin
                        if (raw) begin
                            nst = S_HI;
                        end else if (dtc <= DT_W'(1)) begin
                            nst = S_LO;
                        end else begin
                            ndtc = dtc - DT_W'(1);
                        end
                    end
                    default: nst = S_IDLE;
                endcase
            end
        end

        // State and gate outputs registered from the same next state
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                st   <= S_IDLE;
                dtc  <= '0;
                hi_q <= 1'b0;
                lo_q <= 1'b0;
            end else begin
                st   <= nst;
                dtc  <= ndtc;
                hi_q <= (nst == S_HI);
                lo_q <= (nst == S_LO);
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_dt.sv
// Bench for pwm_multi_dt: phase table with per-cycle scoreboard
// and hand sequences for shadow timing and resets.
module tb_pwm_multi_dt;

    localparam int W  = 8;
    localparam int CH = 3;
    localparam int DW = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            e = 1'b0;
    logic            load = 1'b0;
    logic [W-1:0]    period = '0;
    logic [CH*W-1:0] duty = '0;
    logic [DW-1:0]   dt = '0;
    logic [CH-1:0]   hi;
    logic [CH-1:0]   lo;
    logic [CH-1:0]   full;
    logic            sync;

    always #5 clk = ~clk;

    pwm_multi_dt #(.WIDTH(W), .CH(CH), .DT_W(DW)) dut (
        .CLK(clk), .RSTN(rstn), .E(e), .PERIOD(period),
        .DUTY(duty), .LOAD(load), .DT(dt),
        .HI(hi), .LO(lo), .FULL(full), .SYNC(sync)
    );

    typedef struct {
        logic [CH-1:0] hi;
        logic [CH-1:0] lo;
        logic [CH-1:0] full;
        logic          sync;
    } exp_t;

    typedef struct {
        int           per;
        int           d0;
        int           d1;
        int           d2;
        int           dtv;
        int           nper;
        logic [2:0]   xfull;
        int           xhi1;
        int           xlo1;
    } vec_t;

    exp_t  sbq[$];
    vec_t  tbl[6];
    int    n_vec = 0;
    int    n_err = 0;
    string cur = "reset";

    int m_cnt = 0;
    int m_per = 0;
    int m_duty[CH] = '{0, 0, 0};
    bit m_pend = 0;
    bit m_first = 1;

    // Expected gate outputs after the edge where the counter was c
    function automatic void ch_exp(input int c, input int d, input int p,
                                   input int t, input bit first,
                                   output logic h, output logic l);
        h = 1'b0;
        l = 1'b0;
        if (d == 0) l = 1'b1;
        else if (d > p) h = 1'b1;
        else if (first) begin
            if (c < d) h = 1'b1;
            else if (c >= d + t) l = 1'b1;
        end else if (d <= t) begin
            if (c >= d) l = 1'b1;
        end else begin
            if (c >= t && c < d) h = 1'b1;
            else if (c >= d + t) l = 1'b1;
        end
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_per = 0;
        for (int i = 0; i < CH; i++) m_duty[i] = 0;
        m_pend = 0;
        m_first = 1;
    endtask

    task automatic step(input bit ie, input bit ild, input int iper,
                        input logic [CH*W-1:0] idu, input int idt);
        exp_t x;
        exp_t g;
        int   c;
        logic h;
        logic l;
        e = ie;
        load = ild;
        period = W'(iper);
        duty = idu;
        dt = DW'(idt);
        x.hi = '0;
        x.lo = '0;
        x.full = '0;
        x.sync = 1'b0;
        if (!ie) begin
            m_cnt = 0;
            m_per = iper;
            for (int i = 0; i < CH; i++) m_duty[i] = int'(idu[i*W +: W]);
            m_pend = 0;
            m_first = 1;
        end else begin
            c = m_cnt;
            for (int i = 0; i < CH; i++) begin
                ch_exp(c, m_duty[i], m_per, idt, m_first, h, l);
                x.hi[i] = h;
                x.lo[i] = l;
                x.full[i] = (m_duty[i] > m_per);
            end
            x.sync = (c == m_per);
            if (c == m_per) begin
                m_cnt = 0;
                m_first = 0;
                if (m_pend || ild) begin
                    m_per = iper;
                    for (int i = 0; i < CH; i++)
                        m_duty[i] = int'(idu[i*W +: W]);
                    m_pend = 0;
                end
            end else begin
                m_cnt = c + 1;
                if (ild) m_pend = 1;
            end
        end
        sbq.push_back(x);
        @(posedge clk);
        @(negedge clk);
        g = sbq.pop_front();
        n_vec++;
        if (hi !== g.hi) begin
            n_err++;
            $display("FAIL %s hi: got %b want %b", cur, hi, g.hi);
        end
        if (lo !== g.lo) begin
            n_err++;
            $display("FAIL %s lo: got %b want %b", cur, lo, g.lo);
        end
        if (full !== g.full) begin
            n_err++;
            $display("FAIL %s full: got %b want %b", cur, full, g.full);
        end
        if (sync !== g.sync) begin
            n_err++;
            $display("FAIL %s sync: got %b want %b", cur, sync, g.sync);
        end
        if ((hi & lo) != '0) begin
            n_err++;
            $display("FAIL %s overlap: hi %b lo %b want no overlap", cur, hi, lo);
        end
    endtask

    task automatic chk_zero(input string nm);
        n_vec++;
        if ({hi, lo, full, sync} !== '0) begin
            n_err++;
            $display("FAIL %s: hi %b lo %b full %b sync %b want all 0",
                     nm, hi, lo, full, sync);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // Shadow timing: LOAD mid-period, absorbed LOAD, LOAD on boundary
    task automatic shadow_seq();
        int           h0;
        int           h1;
        int           h2;
        logic [W-1:0] d1;
        bit           ld;
        h0 = 0;
        h1 = 0;
        h2 = 0;
        cur = "shadow";
        for (int k = 0; k < 40; k++) begin
            ld = (k == 3) || (k == 6) || (k == 19);
            d1 = (k < 3) ? W'(5) : (k < 19) ? W'(2) : W'(7);
            step(1, ld, 9, {W'(10), d1, W'(0)}, 0);
            if (k < 10) h0 += int'(hi[1]);
            else if (k < 20) h1 += int'(hi[1]);
            else if (k < 30) h2 += int'(hi[1]);
        end
        chk_int("shadow old period hi", h0, 5);
        chk_int("shadow after mid load hi", h1, 2);
        chk_int("shadow boundary load hi", h2, 7);
    endtask

    initial begin
        int               len;
        int               h1;
        int               l1;
        logic [CH*W-1:0]  dv;

        tbl[0] = '{9, 0, 5, 10, 0, 3, 3'b100, 5, 5};
        tbl[1] = '{9, 0, 5, 10, 2, 3, 3'b100, 3, 3};
        tbl[2] = '{9, 0, 2, 10, 4, 3, 3'b100, 0, 8};
        tbl[3] = '{19, 7, 12, 20, 3, 3, 3'b100, 9, 5};
        tbl[4] = '{0, 0, 1, 255, 2, 8, 3'b110, 1, 0};
        tbl[5] = '{255, 128, 255, 0, 0, 2, 3'b000, 255, 1};

        rstn = 1'b0;
        e = 1'b1;
        load = 1'b1;
        period = W'($urandom);
        duty = CH*W'($urandom);
        dt = DW'($urandom);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_zero("reset held");
        end
        e = 1'b0;
        load = 1'b0;
        rstn = 1'b1;
        model_reset();
        step(0, 0, 200, CH*W'($urandom), 3);
        step(0, 0, 7, {W'(9), W'(1), W'(3)}, 0);

        for (int p = 0; p < 6; p++) begin
            $sformat(cur, "phase%0d", p);
            len = tbl[p].per + 1;
            dv = {W'(tbl[p].d2), W'(tbl[p].d1), W'(tbl[p].d0)};
            step(0, 0, tbl[p].per, dv, tbl[p].dtv);
            h1 = 0;
            l1 = 0;
            for (int k = 0; k < tbl[p].nper * len; k++) begin
                step(1, 0, tbl[p].per, dv, tbl[p].dtv);
                if (k >= (tbl[p].nper - 1) * len) begin
                    h1 += int'(hi[1]);
                    l1 += int'(lo[1]);
                end
            end
            chk_int({cur, " ch1 hi cycles"}, h1, tbl[p].xhi1);
            chk_int({cur, " ch1 lo cycles"}, l1, tbl[p].xlo1);
            chk_int({cur, " full"}, int'(full), int'(tbl[p].xfull));
            if (p == 0) shadow_seq();
            $sformat(cur, "phase%0d tail", p);
            for (int k = 0; k < 3; k++)
                step(1, 0, tbl[p].per, dv, tbl[p].dtv);
        end

        cur = "drop E";
        step(0, 0, 9, {W'(10), W'(5), W'(0)}, 2);
        for (int k = 0; k < 14; k++)
            step(1, 0, 9, {W'(10), W'(5), W'(0)}, 2);
        #2 rstn = 1'b0;
        #1 chk_zero("async reset");
        model_reset();
        @(negedge clk);
        chk_zero("reset low mid run");
        rstn = 1'b1;
        cur = "after reset";
        step(0, 0, 9, {W'(10), W'(5), W'(0)}, 2);
        for (int k = 0; k < 25; k++)
            step(1, 0, 9, {W'(10), W'(5), W'(0)}, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
